// File: rtl/enoc_inject_arbiter_pkg.sv
// Shared ENoC definitions: packet format, default sizes, output-register states.
package enoc_inject_arbiter_pkg;

  localparam int ENOC_N_REQ = 4;
  localparam int ENOC_CNT_W = 16;

  typedef struct packed {
    logic [7:0]  dst;
    logic [23:0] payload;
  } packet_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

endpackage

// File: rtl/enoc_inject_arbiter_rr_select.sv
// enoc_rr_select: first set request at or above ptr, wrapping to 0.
module enoc_rr_select #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  // rotate the search start to ptr; the first hit wins
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = PW'(j);
      end
    end
    if (any) gnt = {{(N-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/enoc_inject_arbiter.sv
// enoc_inject_arbiter: N_REQ sources share one network input port through a
// round-robin arbiter feeding a single-entry output register.
// Optional: define ENOC_ARB_STATS_EN for per-source saturating grant counters
// on o_grant_cnt.
module enoc_inject_arbiter
  import enoc_inject_arbiter_pkg::*;
#(
  parameter int N_REQ = ENOC_N_REQ,
  parameter int CNT_W = ENOC_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  packet_t [N_REQ-1:0]  i_data,
  input  logic    [N_REQ-1:0]  i_data_val,
  output logic    [N_REQ-1:0]  o_en,
  output packet_t              o_data,
  output logic                 o_data_val,
  input  logic                 i_en
`ifdef ENOC_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][CNT_W-1:0] o_grant_cnt
`endif
);

  localparam int PW = $clog2(N_REQ);

  ostate_t       state;
  logic [PW-1:0] ptr, ptr_nxt, win_idx;
  logic [N_REQ-1:0] win_gnt;
  logic          win_any, can_accept, accept;

  enoc_rr_select #(.N(N_REQ), .PW(PW)) u_rr (
    .req (i_data_val),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // slot is free, or is being drained this very cycle; reset_n gates the
  // handshake so o_en drops the instant reset asserts
  always_comb begin
    can_accept = (state == ST_EMPTY) || i_en;
    accept     = reset_n && can_accept && win_any;
    o_en       = accept ? win_gnt : '0;
    ptr_nxt    = (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + PW'(1);
  end

  assign o_data_val = (state == ST_FULL);

  // output register FSM: load on accept, drain on i_en, hold on stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_EMPTY;
      o_data <= '0;
      ptr    <= '0;
    end else begin
      if (accept) begin
        o_data <= i_data[win_idx];
        state  <= ST_FULL;
        ptr    <= ptr_nxt;
      end else if (state == ST_FULL && i_en) begin
        state  <= ST_EMPTY;
      end
    end
  end

`ifdef ENOC_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] grant_cnt;

  // per-source accepted-packet counters, sticking at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (accept && win_gnt[i] && (grant_cnt[i] != {CNT_W{1'b1}}))
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
    end
  end

  assign o_grant_cnt = grant_cnt;
`endif

endmodule

// File: tb/tb_enoc_inject_arbiter.sv
// Randomized + directed bench for enoc_inject_arbiter against a queue-based
// reference model. Define ENOC_ARB_STATS_EN to also cover the grant counters.
module tb_enoc_inject_arbiter;
  import enoc_inject_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  packet_t [N-1:0]  i_data;
  logic    [N-1:0]  i_data_val;
  logic    [N-1:0]  o_en;
  packet_t          o_data;
  logic             o_data_val;
  logic             i_en;
`ifdef ENOC_ARB_STATS_EN
  logic [N-1:0][CNT_W-1:0] grant_cnt;
`endif

  enoc_inject_arbiter #(.N_REQ(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_data     (i_data),
    .i_data_val (i_data_val),
    .o_en       (o_en),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .i_en       (i_en)
`ifdef ENOC_ARB_STATS_EN
    ,
    .o_grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  packet_t q[$];
  int      mptr;
  int      seq   [N];
  int      waitc [N];
  int      mcnt  [N];
  logic [N-1:0] last_en;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic packet_t mk_pkt(input int s);
    packet_t p;
    p.dst     = 8'(s);
    p.payload = 24'(seq[s]);
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    mptr = 0;
    for (int s = 0; s < N; s++) begin
      waitc[s] = 0;
      mcnt[s]  = 0;
    end
  endtask

  // called at posedge+1: drive, check at negedge, advance model, return at next posedge+1
  task automatic step(input logic [N-1:0] val, input logic en);
    logic [N-1:0] exp_en;
    logic         full, can;
    int           w;
    i_data_val = val;
    i_en       = en;
    for (int s = 0; s < N; s++) i_data[s] = mk_pkt(s);
    @(negedge clk);
    full   = (q.size() != 0);
    can    = !full || en;
    w      = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && val[(mptr + k) % N]) w = (mptr + k) % N;
    exp_en = (can && w >= 0) ? N'(1) << w : '0;
    chk("o_data_val", 64'(o_data_val), 64'(full));
    if (full) chk("o_data", 64'(o_data), 64'(q[0]));
    chk("o_en", 64'(o_en), 64'(exp_en));
    last_en = o_en;
    // fairness bookkeeping from what the DUT actually granted
    for (int s = 0; s < N; s++) begin
      if (!val[s]) waitc[s] = 0;
      else if (o_en[s]) begin
        chk("starve", 64'(waitc[s] <= N-1), 64'd1);
        waitc[s] = 0;
      end else if (o_en != '0) waitc[s]++;
    end
    if (full && en) void'(q.pop_front());
    if (exp_en != '0) begin
      q.push_back(mk_pkt(w));
      seq[w]++;
      mptr = (w + 1) % N;
      if (mcnt[w] < (1 << CNT_W) - 1) mcnt[w]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    i_data_val = '0;
    i_en       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rv;
    for (int s = 0; s < N; s++) seq[s] = 0;
    i_data     = '0;
    i_data_val = '0;
    i_en       = 1'b0;
    reset_n    = 1'b0;
    model_reset();
    #3;
    chk("rst_val", 64'(o_data_val), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_en", 64'(o_en), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // all sources valid, network always ready: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1);
      chk("rr_seq", 64'(last_en), 64'(N'(1) << (k % N)));
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // source 2 alone, then a 5-cycle stall
    do_reset();
    step(4'b0100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(4'b0100, 1'b0);
      chk("stall_en2", 64'(last_en[2]), 64'd0);
    end
    step(4'b0100, 1'b1);
    chk("resume_en2", 64'(last_en[2]), 64'd1);
    step(4'b0000, 1'b1);

    // ptr at 3 with sources 0 and 3 requesting
    do_reset();
    step(4'b0100, 1'b1);
    step(4'b1001, 1'b1);
    chk("wrap_w3", 64'(last_en), 64'b1000);
    step(4'b1001, 1'b1);
    chk("wrap_w0", 64'(last_en), 64'b0001);
    step(4'b0000, 1'b1);

    // asynchronous reset while holding a stalled packet
    step(4'b0010, 1'b0);
    i_data_val = 4'b1111;
    i_en       = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_val", 64'(o_data_val), 64'd0);
    chk("arst_data", 64'(o_data), 64'd0);
    chk("arst_en", 64'(o_en), 64'd0);
    i_data_val = '0;
    model_reset();
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b1);

`ifdef ENOC_ARB_STATS_EN
    // counter saturation at 4 bits
    do_reset();
    for (int k = 0; k < 20; k++) step(4'b0010, 1'b1);
    for (int s = 0; s < N; s++)
      chk("sat_cnt", 64'(grant_cnt[s]), (s == 1) ? 64'd15 : 64'd0);
    step(4'b0000, 1'b1);
`endif

    // random valid/enable traffic
    do_reset();
    rv = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int s = 0; s < N; s++)
        rv[s] = rv[s] ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
      step(rv, $urandom_range(3) != 0);
    end
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b1);
    chk("drained", 64'(q.size()), 64'd0);
`ifdef ENOC_ARB_STATS_EN
    for (int s = 0; s < N; s++)
      chk("rand_cnt", 64'(grant_cnt[s]), 64'(mcnt[s]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
